// File: rtl/lab4_vector_checker_pkg.sv
// rtl/lab4_vector_checker_pkg.sv - shared types for the vector checker
// Purpose: datapath width, FSM state encoding and the 40-bit ROM vector layout.
// Ports: none (package lab4_pkg).
package lab4_pkg;

  localparam int DATA_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] expected;
  } vec_t;

endpackage

// File: rtl/lab4_vector_checker_if.sv
// rtl/lab4_vector_checker_if.sv - operand/result bundle to the datapath under test
// Purpose: groups the three operands and the returned result.
// Ports: x1/x2/x3 operands (checker -> datapath), y result (datapath -> checker).
// Modports: master = checker side, slave = datapath side.
interface lab4_vector_checker_if;
  import lab4_pkg::*;

  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] x2;
  logic [DATA_W-1:0] x3;
  logic [DATA_W-1:0] y;

  modport master (output x1, output x2, output x3, input y);
  modport slave  (input x1, input x2, input x3, output y);

endinterface

// File: rtl/lab4_vector_rom.sv
// rtl/lab4_vector_rom.sv - combinational index-to-vector lookup
// Purpose: returns {a,b,c,expected} for a vector index, expected = a*b+c mod 1024.
// Ports: idx in 8 (vector index), vec out 40 (vector entry).
module lab4_vector_rom
  import lab4_pkg::*;
(
  input  logic [7:0] idx,
  output vec_t       vec
);

  vec_t              row;
  logic [DATA_W-1:0] page;

  // Sixteen base rows repeat on every 16-index page; the page number is added
  // to both c and expected, which keeps expected consistent and never zero
  // (every base expected lies in 1..1008).
  always_comb begin
    row  = '0;
    page = {6'd0, idx[7:4]};
    case (idx[3:0])
      4'd0:  row = '{10'd3,   10'd5,   10'd7,   10'd22};
      4'd1:  row = '{10'd10,  10'd20,  10'd30,  10'd230};
      4'd2:  row = '{10'd100, 10'd10,  10'd5,   10'd1005};
      4'd3:  row = '{10'd1,   10'd1,   10'd1,   10'd2};
      4'd4:  row = '{10'd32,  10'd32,  10'd1,   10'd1};
      4'd5:  row = '{10'd50,  10'd21,  10'd4,   10'd30};
      4'd6:  row = '{10'd7,   10'd9,   10'd100, 10'd163};
      4'd7:  row = '{10'd12,  10'd12,  10'd12,  10'd156};
      4'd8:  row = '{10'd0,   10'd500, 10'd33,  10'd33};
      4'd9:  row = '{10'd255, 10'd4,   10'd6,   10'd2};
      4'd10: row = '{10'd15,  10'd15,  10'd15,  10'd240};
      4'd11: row = '{10'd64,  10'd8,   10'd8,   10'd520};
      4'd12: row = '{10'd99,  10'd3,   10'd1,   10'd298};
      4'd13: row = '{10'd200, 10'd5,   10'd25,  10'd1};
      4'd14: row = '{10'd31,  10'd33,  10'd2,   10'd1};
      4'd15: row = '{10'd11,  10'd13,  10'd500, 10'd643};
      default: row = '0;
    endcase
    vec.a        = row.a;
    vec.b        = row.b;
    vec.c        = row.c + page;
    vec.expected = row.expected + page;
  end

endmodule

// File: rtl/lab4_vector_checker.sv
// rtl/lab4_vector_checker.sv - plays ROM vectors into a multiply-add datapath and checks y
// Purpose: per vector LOAD (1) + SETTLE (SETTLE_CYCLES) + CHECK (1) cycles.
// Ports: clk, reset_n (async low), start (run request), dp (x1/x2/x3 out, y in),
//        busy, done, pass, err_count[8], vec_idx[8], first_fail_idx[8], first_fail_valid.
module lab4_vector_checker
  import lab4_pkg::*;
#(
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  lab4_vector_checker_if.master        dp,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [7:0]                   err_count,
  output logic [7:0]                   vec_idx,
  output logic [7:0]                   first_fail_idx,
  output logic                         first_fail_valid
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] LOAD   = ST_LOAD;
  localparam logic [2:0] SETTLE = ST_SETTLE;
  localparam logic [2:0] CHECK  = ST_CHECK;
  localparam logic [2:0] DONE   = ST_DONE;

  localparam logic [7:0] LAST_IDX   = 8'(NUM_VECTORS - 1);
  localparam logic [7:0] SETTLE_VAL = 8'(SETTLE_CYCLES);

  logic [2:0]        state;
  logic [7:0]        settle_cnt;
  logic [DATA_W-1:0] expected;
  vec_t              rom_vec;

  lab4_vector_rom u_rom (
    .idx (vec_idx),
    .vec (rom_vec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      expected         <= '0;
      err_count        <= '0;
      vec_idx          <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      dp.x1            <= '0;
      dp.x2            <= '0;
      dp.x3            <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= LOAD;
            vec_idx          <= '0;
            err_count        <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        LOAD: begin
          dp.x1      <= rom_vec.a;
          dp.x2      <= rom_vec.b;
          dp.x3      <= rom_vec.c;
          expected   <= rom_vec.expected;
          settle_cnt <= SETTLE_VAL;
          state      <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 8'd1;
          // Counter holds SETTLE_CYCLES on the first SETTLE cycle, so leaving
          // at 1 gives exactly SETTLE_CYCLES cycles here.
          if (settle_cnt <= 8'd1) state <= CHECK;
        end
        CHECK: begin
          if (dp.y != expected) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (!first_fail_valid) begin
              first_fail_idx   <= vec_idx;
              first_fail_valid <= 1'b1;
            end
          end
          if (vec_idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            vec_idx <= vec_idx + 8'd1;
            state   <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == 8'd0);

endmodule

// File: tb/tb_lab4_vector_checker.sv
// tb/tb_lab4_vector_checker.sv - directed self-checking bench for lab4_vector_checker
module tb_lab4_vector_checker;
  import lab4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start_a, start_b, start_c;
  logic corrupt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] madd(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [19:0] p;
    p = a * b + {10'd0, c};
    return p[9:0];
  endfunction

  lab4_vector_checker_if if_a ();
  lab4_vector_checker_if if_b ();
  lab4_vector_checker_if if_c ();

  logic       busy_a, done_a, pass_a, ffv_a;
  logic [7:0] err_a, idx_a, ffi_a;
  logic       busy_b, done_b, pass_b, ffv_b;
  logic [7:0] err_b, idx_b, ffi_b;
  logic       busy_c, done_c, pass_c, ffv_c;
  logic [7:0] err_c, idx_c, ffi_c;

  assign if_a.y = madd(if_a.x1, if_a.x2, if_a.x3) ^ {9'd0, corrupt && (idx_a == 8'd2)};
  assign if_b.y = '0;
  assign if_c.y = madd(if_c.x1, if_c.x2, if_c.x3);

  lab4_vector_checker #(.NUM_VECTORS(4), .SETTLE_CYCLES(4)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .dp(if_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .vec_idx(idx_a), .first_fail_idx(ffi_a), .first_fail_valid(ffv_a));

  lab4_vector_checker #(.NUM_VECTORS(256), .SETTLE_CYCLES(4)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .dp(if_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .vec_idx(idx_b), .first_fail_idx(ffi_b), .first_fail_valid(ffv_b));

  lab4_vector_checker #(.NUM_VECTORS(4), .SETTLE_CYCLES(1)) u_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .dp(if_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .vec_idx(idx_c), .first_fail_idx(ffi_c), .first_fail_valid(ffv_c));

  // Operands of u_c may only change on the edge that leaves LOAD.
  int          xchg_c = 0;
  logic [2:0]  pre_state_c;
  logic [29:0] pre_x_c;
  always @(posedge clk) begin
    pre_state_c = u_c.state;
    pre_x_c     = {if_c.x1, if_c.x2, if_c.x3};
    #1;
    if ({if_c.x1, if_c.x2, if_c.x3} != pre_x_c) begin
      xchg_c++;
      chk("c_x_change_on_load", 32'(pre_state_c), 32'(ST_LOAD));
    end
  end

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  function automatic logic done_of(input int w);
    return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
  endfunction

  logic [7:0] snap_err, snap_idx;
  logic       snap_busy, snap_ffv, snap_pass;

  // Raises start for `hold` sampling edges and returns the number of edges
  // after the first sampling edge until done is seen.
  task automatic run(input int w, input int hold, input int budget, output int n);
    @(negedge clk);
    set_start(w, 1'b1);
    @(posedge clk);
    #1;
    snap_err = err_a; snap_idx = idx_a; snap_busy = busy_a;
    snap_ffv = ffv_a; snap_pass = pass_a;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (n + 1 >= hold) set_start(w, 1'b0);
      @(posedge clk);
      n++;
      #1;
      if (done_of(w)) break;
    end
    set_start(w, 1'b0);
    if (!done_of(w)) chk("run_timeout", 0, 1);
  endtask

  task automatic check_a_zero(input string tag);
    chk({tag, "_busy"},  32'(busy_a), 0);
    chk({tag, "_done"},  32'(done_a), 0);
    chk({tag, "_pass"},  32'(pass_a), 0);
    chk({tag, "_err"},   32'(err_a), 0);
    chk({tag, "_idx"},   32'(idx_a), 0);
    chk({tag, "_ffi"},   32'(ffi_a), 0);
    chk({tag, "_ffv"},   32'(ffv_a), 0);
    chk({tag, "_x1"},    32'(if_a.x1), 0);
    chk({tag, "_x2"},    32'(if_a.x2), 0);
    chk({tag, "_x3"},    32'(if_a.x3), 0);
    chk({tag, "_state"}, 32'(u_a.state), 32'(ST_IDLE));
  endtask

  int n;

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    corrupt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_a_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset_busy", 32'(busy_a), 0);

    // Golden run: 4 vectors x 6 cycles.
    run(0, 1, 100, n);
    chk("gold_latency", n, 24);
    chk("gold_pass", 32'(pass_a), 1);
    chk("gold_err", 32'(err_a), 0);
    chk("gold_ffv", 32'(ffv_a), 0);
    chk("gold_last_idx", 32'(idx_a), 3);
    chk("gold_hold_x", {2'b0, if_a.x1, if_a.x2, if_a.x3}, {2'b0, 10'd1, 10'd1, 10'd1});

    // Corrupt y on index 2 only, restarting from DONE.
    corrupt = 1'b1;
    run(0, 1, 100, n);
    chk("corr_latency", n, 24);
    chk("corr_err", 32'(err_a), 1);
    chk("corr_ffi", 32'(ffi_a), 2);
    chk("corr_ffv", 32'(ffv_a), 1);
    chk("corr_pass", 32'(pass_a), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("corr_hold_done", 32'(done_a), 1);
    chk("corr_hold_err", 32'(err_a), 1);

    // Restart from DONE with start held for 10 cycles.
    corrupt = 1'b0;
    run(0, 10, 100, n);
    chk("restart_err_cleared", 32'(snap_err), 0);
    chk("restart_idx0", 32'(snap_idx), 0);
    chk("restart_busy", 32'(snap_busy), 1);
    chk("restart_ffv_cleared", 32'(snap_ffv), 0);
    chk("restart_pass_low", 32'(snap_pass), 0);
    chk("held_start_latency", n, 24);
    chk("held_start_pass", 32'(pass_a), 1);

    // Reset during SETTLE of index 1 (8 edges after the sampling edge).
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrun_idx", 32'(idx_a), 1);
    chk("midrun_state", 32'(u_a.state), 32'(ST_SETTLE));
    chk("midrun_x1", 32'(if_a.x1), 10);
    reset_n = 1'b0;
    #1;
    check_a_zero("midrun_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(busy_a), 0);
    run(0, 1, 100, n);
    chk("post_reset_latency", n, 24);
    chk("post_reset_pass", 32'(pass_a), 1);

    // y stuck at zero over 256 vectors: error count saturates.
    run(1, 1, 2000, n);
    chk("stuck_latency", n, 1536);
    chk("stuck_err_sat", 32'(err_b), 255);
    chk("stuck_ffi", 32'(ffi_b), 0);
    chk("stuck_ffv", 32'(ffv_b), 1);
    chk("stuck_pass", 32'(pass_b), 0);

    // SETTLE_CYCLES=1: 3 cycles per vector.
    run(2, 1, 100, n);
    chk("fast_latency", n, 12);
    chk("fast_pass", 32'(pass_c), 1);
    chk("fast_x_changes", xchg_c, 4);
    chk("fast_hold_x", {2'b0, if_c.x1, if_c.x2, if_c.x3}, {2'b0, 10'd1, 10'd1, 10'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
